// File: rtl/instruction_store_pkg.sv
// Shared definitions for the instruction store: controller state encoding and
// the default value returned for fetches that have no loaded instruction.
package instruction_store_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } store_state_e;

  localparam int unsigned NOP_WORD_DEFAULT = 32'd0;

endpackage

// File: rtl/instruction_store_bram_sdp.sv
// Simple dual-port storage array: one write port and one registered read port.
// The read register holds its value while no read is requested.
module bram_sdp #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_store.sv
// Instruction store: loads a big-endian byte stream into a word RAM and serves
// single-cycle-latency fetches, returning NOP_WORD for anything not loaded.
module instruction_store
  import instruction_store_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NOP_WORD_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic [7:0]            load_byte,
  input  logic                  load_byte_valid,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int unsigned DEPTH  = 2**ADDR_WIDTH;
  localparam int unsigned LEN_W  = ADDR_WIDTH + 1;
  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  store_state_e          state_q;
  logic [LEN_W-1:0]      wr_ptr_q;
  logic [LEN_W-1:0]      word_count_q;
  logic [LEN_W-1:0]      load_len_q;
  logic [BIDX_W-1:0]     byte_idx_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  load_done_q;
  logic                  load_error_q;
  logic                  fetch_valid_q;
  logic                  fetch_nop_q;

  logic                  byte_accept;
  logic                  last_byte;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] word_d;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // load_start takes priority over any byte presented in the same cycle
  assign byte_accept = (state_q == S_LOAD) && load_byte_valid && !load_start;
  assign last_byte   = (byte_idx_q == BIDX_W'(BYTES - 1));
  assign ram_we      = byte_accept && last_byte;
  assign word_d      = (word_q << 8) | DATA_WIDTH'(load_byte);

  bram_sdp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (word_d),
    .re_i    (fetch_en),
    .raddr_i (fetch_addr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (byte_accept) begin
      word_q <= word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      word_count_q  <= '0;
      load_len_q    <= '0;
      byte_idx_q    <= '0;
      load_done_q   <= 1'b0;
      load_error_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_nop_q   <= 1'b1;
    end else begin
      load_done_q   <= 1'b0;
      load_error_q  <= 1'b0;
      fetch_valid_q <= fetch_en;
      if (fetch_en) begin
        fetch_nop_q <= (state_q != S_READY) ||
                       ({1'b0, fetch_addr} >= word_count_q);
      end

      if (load_start) begin
        if (load_len > LEN_W'(DEPTH)) begin
          load_error_q <= 1'b1;
          if (state_q == S_LOAD) begin
            state_q <= S_IDLE;
          end
        end else if (load_len == '0) begin
          state_q      <= S_READY;
          word_count_q <= '0;
          load_done_q  <= 1'b1;
        end else begin
          state_q    <= S_LOAD;
          load_len_q <= load_len;
          wr_ptr_q   <= '0;
          byte_idx_q <= '0;
        end
      end else if (byte_accept) begin
        if (last_byte) begin
          byte_idx_q <= '0;
          // final word: hold wr_ptr so a full-depth load never wraps
          if (wr_ptr_q + LEN_W'(1) == load_len_q) begin
            word_count_q <= load_len_q;
            state_q      <= S_READY;
            load_done_q  <= 1'b1;
          end else begin
            wr_ptr_q <= wr_ptr_q + LEN_W'(1);
          end
        end else begin
          byte_idx_q <= byte_idx_q + BIDX_W'(1);
        end
      end
    end
  end

  assign instr       = fetch_nop_q ? NOP_WORD : ram_rdata;
  assign instr_valid = fetch_valid_q;
  assign load_busy   = (state_q == S_LOAD);
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;

endmodule

// File: tb/tb_instruction_store.sv
// Directed bench for instruction_store with a program-level reference model
// checked every cycle, plus literal expectations for key fetches.
module tb_instruction_store;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic [5:0]  fetch_addr = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        load_start = 1'b0;
  logic [6:0]  load_len = '0;
  logic [7:0]  load_byte = '0;
  logic        load_byte_valid = 1'b0;
  logic        load_busy;
  logic        load_done;
  logic        load_error;

  always #5 clk = ~clk;

  instruction_store #(
    .ADDR_WIDTH (6),
    .DATA_WIDTH (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .fetch_addr      (fetch_addr),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .load_start      (load_start),
    .load_len        (load_len),
    .load_byte       (load_byte),
    .load_byte_valid (load_byte_valid),
    .load_busy       (load_busy),
    .load_done       (load_done),
    .load_error      (load_error)
  );

  int checks = 0;
  int errors = 0;

  // Program-level model: what has been committed, and whether it is servable.
  logic [31:0] m_prog [DEPTH];
  bit          m_ready = 0;
  bit          m_loading = 0;
  bit          m_done_now = 0;
  bit          m_err_now = 0;
  int          m_count = 0;
  int          m_len = 0;
  logic [7:0]  m_bytes [$];
  logic [7:0]  stim [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic [31:0] pend_instr = NOP;
  bit          pend_valid = 0;
  bit          started = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        started    = 1;
        pend_valid = 0;
        pend_instr = NOP;
      end else if (fetch_en) begin
        pend_valid = 1;
        pend_instr = (m_ready && int'(fetch_addr) < m_count) ? m_prog[fetch_addr] : NOP;
      end else begin
        pend_valid = 0;
      end
      #2;
      if (started) begin
        chk("instr_valid", 32'(instr_valid), 32'(pend_valid));
        chk("instr", instr, pend_instr);
        chk("load_busy", 32'(load_busy), 32'(m_loading));
        chk("load_done", 32'(load_done), 32'(m_done_now));
        chk("load_error", 32'(load_error), 32'(m_err_now));
        m_done_now = 0;
        m_err_now  = 0;
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    m_ready   = 0;
    m_count   = 0;
    m_loading = 0;
  endtask

  task automatic start_load(int len, bit garbage);
    load_start      = 1'b1;
    load_len        = 7'(len);
    load_byte_valid = garbage;
    load_byte       = 8'hEE;
    @(posedge clk);
    #1;
    load_start      = 1'b0;
    load_byte_valid = 1'b0;
    if (len > DEPTH) begin
      m_err_now = 1;
      m_loading = 0;
    end else if (len == 0) begin
      m_ready    = 1;
      m_count    = 0;
      m_loading  = 0;
      m_done_now = 1;
    end else begin
      m_ready   = 0;
      m_loading = 1;
      m_len     = len;
      m_bytes.delete();
    end
  endtask

  task automatic send_stream(bit with_fetch);
    for (int i = 0; i < stim.size(); i++) begin
      load_byte       = stim[i];
      load_byte_valid = 1'b1;
      fetch_en        = with_fetch && (i % 2 == 1);
      fetch_addr      = 6'(i / 4);
      @(posedge clk);
      #1;
      if (m_loading) begin
        m_bytes.push_back(stim[i]);
        if (m_bytes.size() == m_len * 4) begin
          for (int w = 0; w < m_len; w++)
            m_prog[w] = {m_bytes[4*w], m_bytes[4*w+1], m_bytes[4*w+2], m_bytes[4*w+3]};
          m_count    = m_len;
          m_ready    = 1;
          m_loading  = 0;
          m_done_now = 1;
        end
      end
    end
    load_byte_valid = 1'b0;
    fetch_en        = 1'b0;
  endtask

  task automatic fetch_lit(int addr, logic [31:0] exp, string name);
    fetch_en   = 1'b1;
    fetch_addr = 6'(addr);
    @(posedge clk);
    #1;
    fetch_en = 1'b0;
    #2;
    chk(name, instr, exp);
    chk({name, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic sweep(int lo, int hi);
    fetch_en = 1'b1;
    for (int a = lo; a <= hi; a++) begin
      fetch_addr = 6'(a);
      @(posedge clk);
      #1;
    end
    fetch_en = 1'b0;
  endtask

  initial begin
    do_reset();
    idle(2);
    fetch_lit(0, 32'h0000_0000, "reset_fetch0");
    chk("reset_busy", 32'(load_busy), 32'd0);

    start_load(2, 1'b0);
    stim = '{8'h28, 8'h02, 8'h00, 8'h05, 8'h2A, 8'h03, 8'h00, 8'h0C};
    send_stream(1'b1);
    idle(1);
    fetch_lit(0, 32'h2802_0005, "two_word_w0");
    fetch_lit(1, 32'h2A03_000C, "two_word_w1");
    fetch_lit(2, 32'h0000_0000, "two_word_w2_nop");
    stim = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_stream(1'b0);
    fetch_lit(0, 32'h2802_0005, "ready_bytes_ignored");
    start_load(65, 1'b0);
    idle(1);
    fetch_lit(1, 32'h2A03_000C, "error_keeps_program");

    do_reset();
    start_load(65, 1'b1);
    idle(2);
    fetch_lit(0, 32'h0000_0000, "oversize_fetch_nop");
    chk("oversize_busy", 32'(load_busy), 32'd0);

    start_load(2, 1'b0);
    stim = '{8'hAA, 8'hBB, 8'hCC};
    send_stream(1'b0);
    start_load(1, 1'b1);
    stim = '{8'h10, 8'h07, 8'h00, 8'h00};
    send_stream(1'b1);
    idle(1);
    fetch_lit(0, 32'h1007_0000, "restart_w0");
    fetch_lit(1, 32'h0000_0000, "restart_w1_nop");

    start_load(0, 1'b0);
    idle(1);
    fetch_lit(0, 32'h0000_0000, "len0_fetch_nop");

    start_load(64, 1'b0);
    stim.delete();
    for (int j = 0; j < 256; j++) stim.push_back(8'(j) ^ 8'h5A);
    send_stream(1'b1);
    idle(1);
    fetch_lit(63, 32'hA6A7_A4A5, "full_w63");
    fetch_lit(0, 32'h5A5B_5859, "full_w0");
    sweep(0, 63);
    idle(2);

    start_load(4, 1'b0);
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_stream(1'b0);
    do_reset();
    chk("midload_reset_busy", 32'(load_busy), 32'd0);
    sweep(0, 3);
    fetch_lit(0, 32'h0000_0000, "midload_reset_nop");
    fetch_lit(63, 32'h0000_0000, "midload_reset_nop63");
    start_load(1, 1'b0);
    stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_stream(1'b1);
    idle(1);
    fetch_lit(0, 32'hDEAD_BEEF, "reload_w0");
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
